// File: rtl/i2c_reg_seq.sv
// Register-access sequencer in front of i2c_master: one burst request becomes
// pointer-write + data transactions per byte. Optional abort timer: I2C_SEQ_TIMEOUT_EN.
module i2c_reg_seq #(
    parameter int LEN_W          = 4,
    parameter int TIMEOUT_CYCLES = 100000
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             req_valid,
    output logic             req_ready,
    input  logic             req_write,
    input  logic [6:0]       req_dev_addr,
    input  logic [7:0]       req_reg_addr,
    input  logic [LEN_W-1:0] req_len,
    input  logic [7:0]       wr_data,
    input  logic             wr_valid,
    output logic             wr_ready,
    output logic [7:0]       rd_data,
    output logic             rd_valid,
    input  logic             rd_ready,
    output logic             seq_done,
    output logic             seq_err,
    output logic             m_start,
    output logic             m_read_write,
    output logic [6:0]       m_slave_addr,
    output logic [7:0]       m_data_in,
    input  logic [7:0]       m_data_out,
    input  logic             m_busy,
    input  logic             m_done
);

    typedef enum logic [2:0] {
        IDLE, PTR_ISSUE, PTR_WAIT, DAT_ISSUE, DAT_WAIT, RD_HOLD, DONE
    } state_t;

    state_t           state, state_nxt;
    logic             armed;
    logic             wr_q;
    logic [6:0]       dev_q;
    logic [7:0]       reg_q;
    logic [7:0]       wbyte_q;
    logic [LEN_W-1:0] len_q;
    logic [LEN_W-1:0] cnt_q;
    logic             accept;
    logic             ptr_go;
    logic             dat_go;
    logic             last;
    logic             byte_adv;
    logic             tmo_hit;

    assign accept   = req_valid && req_ready;
    assign ptr_go   = (state == PTR_ISSUE) && !m_busy;
    assign dat_go   = (state == DAT_ISSUE) && !m_busy && (!wr_q || wr_valid);
    assign last     = (cnt_q == (len_q - 1'b1));
    assign byte_adv = ((state == DAT_WAIT) && m_done && wr_q) ||
                      ((state == RD_HOLD) && rd_ready);
    assign m_slave_addr = dev_q;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state <= IDLE;
        end else begin
            state <= state_nxt;
        end
    end

    always_comb begin
        state_nxt = state;
        case (state)
            IDLE:      if (accept) state_nxt = (req_len == '0) ? DONE : PTR_ISSUE;
            PTR_ISSUE: if (ptr_go) state_nxt = PTR_WAIT;
            PTR_WAIT: begin
                if (m_done)       state_nxt = DAT_ISSUE;
                else if (tmo_hit) state_nxt = DONE;
            end
            DAT_ISSUE: if (dat_go) state_nxt = DAT_WAIT;
            DAT_WAIT: begin
                if (m_done) begin
                    if (!wr_q)     state_nxt = RD_HOLD;
                    else if (last) state_nxt = DONE;
                    else           state_nxt = PTR_ISSUE;
                end else if (tmo_hit) begin
                    state_nxt = DONE;
                end
            end
            RD_HOLD:   if (rd_ready) state_nxt = last ? DONE : PTR_ISSUE;
            DONE:      state_nxt = IDLE;
            default:   state_nxt = IDLE;
        endcase
    end

    always_comb begin
        req_ready    = armed && (state == IDLE);
        m_start      = ptr_go || dat_go;
        wr_ready     = dat_go && wr_q;
        seq_done     = (state == DONE);
        m_read_write = 1'b0;
        m_data_in    = 8'h00;
        case (state)
            PTR_ISSUE, PTR_WAIT: m_data_in = reg_q;
            DAT_ISSUE: begin
                m_read_write = !wr_q;
                m_data_in    = wr_q ? wr_data : 8'h00;
            end
            DAT_WAIT: begin
                m_read_write = !wr_q;
                m_data_in    = wr_q ? wbyte_q : 8'h00;
            end
            default: ;
        endcase
    end

    // armed keeps req_ready low until the first edge after reset release
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            armed    <= 1'b0;
            wr_q     <= 1'b0;
            dev_q    <= 7'h00;
            reg_q    <= 8'h00;
            len_q    <= '0;
            cnt_q    <= '0;
            wbyte_q  <= 8'h00;
            rd_data  <= 8'h00;
            rd_valid <= 1'b0;
        end else begin
            armed <= 1'b1;
            if (accept) begin
                wr_q  <= req_write;
                dev_q <= req_dev_addr;
                reg_q <= req_reg_addr;
                len_q <= req_len;
                cnt_q <= '0;
            end else if (byte_adv) begin
                cnt_q <= cnt_q + 1'b1;
                reg_q <= reg_q + 8'd1;
            end
            if (dat_go && wr_q) begin
                wbyte_q <= wr_data;
            end
            if ((state == DAT_WAIT) && m_done && !wr_q) begin
                rd_data  <= m_data_out;
                rd_valid <= 1'b1;
            end else if (((state == RD_HOLD) && rd_ready) || tmo_hit) begin
                rd_valid <= 1'b0;
            end
        end
    end

`ifdef I2C_SEQ_TIMEOUT_EN
    localparam int TMO_W = $clog2(TIMEOUT_CYCLES + 1);

    logic             waiting;
    logic [TMO_W-1:0] tmo_cnt;
    logic             err_q;

    assign waiting = (state == PTR_WAIT) || (state == DAT_WAIT);
    assign tmo_hit = waiting && !m_done && (tmo_cnt == TMO_W'(TIMEOUT_CYCLES - 1));
    assign seq_err = err_q;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            tmo_cnt <= '0;
            err_q   <= 1'b0;
        end else begin
            if (m_start)      tmo_cnt <= '0;
            else if (waiting) tmo_cnt <= tmo_cnt + 1'b1;
            if (accept)       err_q <= 1'b0;
            else if (tmo_hit) err_q <= 1'b1;
        end
    end
`else
    // timer absent: the wait states never abort
    assign tmo_hit = (TIMEOUT_CYCLES < 0);
    assign seq_err = 1'b0;
`endif

endmodule

// File: tb/tb_i2c_reg_seq.sv
// Self-checking bench for i2c_reg_seq: randomized bursts against a transaction-list
// reference model and a behavioural i2c_master responder.
module tb_i2c_reg_seq;

    localparam int LEN_W = 4;
    localparam int TMO   = 50;

    typedef struct packed {
        logic       ptr;
        logic       rw;
        logic [6:0] addr;
        logic [7:0] data;
    } txn_t;

    logic             clk = 1'b0;
    logic             rst_n;
    logic             req_valid, req_ready, req_write;
    logic [6:0]       req_dev_addr;
    logic [7:0]       req_reg_addr;
    logic [LEN_W-1:0] req_len;
    logic [7:0]       wr_data;
    logic             wr_valid, wr_ready;
    logic [7:0]       rd_data;
    logic             rd_valid, rd_ready;
    logic             seq_done, seq_err;
    logic             m_start, m_read_write;
    logic [6:0]       m_slave_addr;
    logic [7:0]       m_data_in, m_data_out;
    logic             m_busy, m_done;

    always #5 clk = ~clk;

    i2c_reg_seq #(.LEN_W(LEN_W), .TIMEOUT_CYCLES(TMO)) dut (
        .clk(clk), .rst_n(rst_n),
        .req_valid(req_valid), .req_ready(req_ready), .req_write(req_write),
        .req_dev_addr(req_dev_addr), .req_reg_addr(req_reg_addr), .req_len(req_len),
        .wr_data(wr_data), .wr_valid(wr_valid), .wr_ready(wr_ready),
        .rd_data(rd_data), .rd_valid(rd_valid), .rd_ready(rd_ready),
        .seq_done(seq_done), .seq_err(seq_err),
        .m_start(m_start), .m_read_write(m_read_write), .m_slave_addr(m_slave_addr),
        .m_data_in(m_data_in), .m_data_out(m_data_out), .m_busy(m_busy), .m_done(m_done)
    );

    int tests = 0;
    int fails = 0;

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        tests++;
        if (got !== exp) begin
            fails++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
        end
    endtask

    // reference model state
    txn_t       exp_q[$];
    logic [7:0] rd_exp_q[$];
    logic [7:0] wr_src_q[$];
    logic [7:0] wr_force_q[$];
    logic [7:0] rd_force_q[$];
    int         start_cnt = 0;
    int         done_cnt  = 0;
    int         hang_from = -1;
    int         rd_mode   = 0;
    bit         model_clr = 0;
    bit         glitch    = 0;

    // responder state
    bit         m_act = 0;
    int         m_left;
    logic       cur_rw;
    logic [6:0] cur_addr;
    logic [7:0] cur_data;
    txn_t       t;
    logic [7:0] v;
    logic       exp_wr;

    initial begin
        m_busy = 0; m_done = 0; m_data_out = 0;
        wr_valid = 0; wr_data = 0; rd_ready = 0;
        forever begin
            @(negedge clk);
            if (rst_n) begin
                exp_wr = m_start && (exp_q.size() > 0) && !exp_q[0].ptr && !exp_q[0].rw;
                check("wr_ready", wr_ready, exp_wr);
                if (m_start) begin
                    start_cnt++;
                    check("start_idle_bus", m_busy, 0);
                    if (exp_q.size() == 0) begin
                        check("extra_start", m_start, 0);
                    end else begin
                        t = exp_q.pop_front();
                        check("txn_rw", m_read_write, t.rw);
                        check("txn_addr", m_slave_addr, t.addr);
                        if (t.ptr || !t.rw) check("txn_data", m_data_in, t.data);
                    end
                    if (wr_ready && wr_src_q.size() > 0) void'(wr_src_q.pop_front());
                    m_act    = 1;
                    cur_rw   = m_read_write;
                    cur_addr = m_slave_addr;
                    cur_data = m_data_in;
                    if (hang_from >= 0 && start_cnt >= hang_from) m_left = -1;
                    else m_left = $urandom_range(1, 6);
                end else if (m_act) begin
                    check("hold_rw", m_read_write, cur_rw);
                    check("hold_addr", m_slave_addr, cur_addr);
                    check("hold_data", m_data_in, cur_data);
                end
                if (rd_valid) begin
                    if (rd_exp_q.size() == 0) begin
                        check("extra_rd", rd_valid, 0);
                    end else begin
                        check("rd_data", rd_data, rd_exp_q[0]);
                        if (rd_ready) void'(rd_exp_q.pop_front());
                    end
                end
                if (seq_done) done_cnt++;
            end
            @(posedge clk);
            #1;
            if (!rst_n || model_clr) begin
                m_act = 0; m_busy = 0; m_done = 0; model_clr = 0;
            end else if (m_done) begin
                m_done = 0; m_act = 0; m_busy = 0;
            end else if (m_act) begin
                m_busy = 1;
                if (m_left > 0) m_left--;
                if (m_left == 0) begin
                    m_done = 1;
                    m_busy = 0;
                    if (cur_rw) begin
                        if (rd_force_q.size() > 0) v = rd_force_q.pop_front();
                        else v = 8'($urandom);
                        m_data_out = v;
                        rd_exp_q.push_back(v);
                    end
                end
            end else begin
                m_busy = ($urandom_range(0, 3) == 0);
                if (glitch) begin
                    m_done = 1;
                    glitch = 0;
                end
            end
            if (wr_src_q.size() > 0) begin
                wr_valid = ($urandom_range(0, 2) != 0);
                wr_data  = wr_src_q[0];
            end else begin
                wr_valid = 0;
                wr_data  = 8'($urandom);
            end
            case (rd_mode)
                0:       rd_ready = 1;
                1:       rd_ready = 1'($urandom_range(0, 1));
                default: rd_ready = 0;
            endcase
        end
    end

    task automatic check_outs_zero(input string tag);
        check(tag, {req_ready, m_start, wr_ready, rd_valid, seq_done, seq_err,
                    m_read_write, m_slave_addr, m_data_in, rd_data}, 0);
    endtask

    task automatic flush_model();
        exp_q.delete(); rd_exp_q.delete(); wr_src_q.delete();
        wr_force_q.delete(); rd_force_q.delete();
    endtask

    task automatic start_req(input logic wr, input logic [6:0] dev, input logic [7:0] rg,
                             input int len);
        txn_t       pt, dt;
        logic [7:0] b;
        bit         got;
        for (int i = 0; i < len; i++) begin
            if (wr_force_q.size() > 0) b = wr_force_q.pop_front();
            else b = 8'($urandom);
            pt = '{ptr: 1'b1, rw: 1'b0, addr: dev, data: 8'(rg + i)};
            dt = '{ptr: 1'b0, rw: !wr, addr: dev, data: wr ? b : 8'h00};
            exp_q.push_back(pt);
            exp_q.push_back(dt);
            if (wr) wr_src_q.push_back(b);
        end
        req_write = wr; req_dev_addr = dev; req_reg_addr = rg; req_len = LEN_W'(len);
        req_valid = 1;
        got = 0;
        for (int k = 0; k < 100 && !got; k++) begin
            @(negedge clk);
            got = req_ready;
            @(posedge clk);
            #1;
        end
        req_valid = 0;
        check("req_accept", got, 1);
    endtask

    task automatic wait_done(input int budget, output int lat);
        lat = 0;
        forever begin
            @(negedge clk);
            lat++;
            if (seq_done) break;
            if (lat >= budget) begin
                check("done_timeout", seq_done, 1);
                break;
            end
        end
        @(posedge clk);
        #1;
    endtask

    task automatic end_burst();
        @(negedge clk);
        check("idle_ready", req_ready, 1);
        check("done_one_cycle", seq_done, 0);
        check("idle_rd_valid", rd_valid, 0);
        check("txn_left", exp_q.size(), 0);
        check("rd_left", rd_exp_q.size(), 0);
        check("wr_left", wr_src_q.size(), 0);
        check("seq_err_clear", seq_err, 0);
        @(posedge clk);
        #1;
    endtask

    task automatic run_burst(input logic wr, input logic [6:0] dev, input logic [7:0] rg,
                             input int len);
        int d0, s0, lat;
        d0 = done_cnt;
        s0 = start_cnt;
        start_req(wr, dev, rg, len);
        wait_done(3000, lat);
        end_burst();
        check("done_count", done_cnt - d0, 1);
        check("start_count", start_cnt - s0, 2 * len);
    endtask

    task automatic pulse_reset();
        @(negedge clk);
        #2;
        rst_n = 0;
        #1;
        check_outs_zero("reset_outs");
        repeat (3) @(posedge clk);
        flush_model();
        @(negedge clk);
        #2;
        rst_n = 1;
        #1;
        check("ready_low_after_release", req_ready, 0);
        @(posedge clk);
        #1;
        check("ready_after_first_edge", req_ready, 1);
    endtask

    initial begin
        int d0, s0, lat, wait_k;
        rst_n = 0;
        req_valid = 0; req_write = 0; req_dev_addr = 0; req_reg_addr = 0; req_len = 0;
        repeat (3) @(posedge clk);
        @(negedge clk);
        check_outs_zero("por_outs");
        #2;
        rst_n = 1;
        #1;
        check("ready_low_after_release", req_ready, 0);
        @(posedge clk);
        #1;
        check("ready_after_first_edge", req_ready, 1);

        // directed read burst with known return bytes
        rd_mode = 0;
        rd_force_q.push_back(8'hA5);
        rd_force_q.push_back(8'h5A);
        run_burst(1'b0, 7'h55, 8'h3B, 2);

        // write burst across the register-address wrap
        wr_force_q.push_back(8'h3C);
        wr_force_q.push_back(8'h11);
        run_burst(1'b1, 7'h21, 8'hFF, 2);

        // read byte held by a stalled consumer, with a stray m_done in between
        rd_mode = 2;
        d0 = done_cnt;
        s0 = start_cnt;
        start_req(1'b0, 7'h10, 8'h80, 1);
        wait_k = 0;
        while (!rd_valid && wait_k < 300) begin
            @(negedge clk);
            wait_k++;
        end
        check("rd_valid_seen", rd_valid, 1);
        @(posedge clk);
        #1;
        for (int i = 0; i < 20; i++) begin
            if (i == 8) glitch = 1;
            @(negedge clk);
            check("rd_hold_valid", rd_valid, 1);
            @(posedge clk);
            #1;
        end
        check("hold_no_start", start_cnt - s0, 2);
        check("hold_no_done", done_cnt - d0, 0);
        rd_mode = 0;
        wait_done(100, lat);
        end_burst();
        check("hold_done_count", done_cnt - d0, 1);

        // zero-length request
        d0 = done_cnt;
        s0 = start_cnt;
        start_req(1'b1, 7'h2A, 8'h00, 0);
        wait_done(20, lat);
        check("len0_latency_le2", (lat >= 1) && (lat <= 2), 1);
        end_burst();
        check("len0_no_start", start_cnt - s0, 0);
        check("len0_done_count", done_cnt - d0, 1);

        // reset while the first data read of a 3-byte burst is outstanding
        d0 = done_cnt;
        s0 = start_cnt;
        hang_from = start_cnt + 2;
        start_req(1'b0, 7'h33, 8'h40, 3);
        wait_k = 0;
        while (start_cnt < s0 + 2 && wait_k < 300) begin
            @(negedge clk);
            wait_k++;
        end
        check("reached_dat_wait", start_cnt - s0, 2);
        hang_from = -1;
        pulse_reset();
        repeat (4) @(posedge clk);
        #1;
        check("reset_no_done", done_cnt - d0, 0);
        run_burst(1'b0, 7'h33, 8'h40, 3);

        // randomized bursts
        rd_mode = 1;
        for (int k = 0; k < 25; k++) begin
            run_burst(1'($urandom_range(0, 1)), 7'($urandom),
                      (k % 4 == 0) ? 8'hFC : 8'($urandom), $urandom_range(0, 15));
        end
        rd_mode = 0;

`ifdef I2C_SEQ_TIMEOUT_EN
        // master never answers: abort after the timeout
        d0 = done_cnt;
        hang_from = start_cnt + 1;
        start_req(1'b0, 7'h44, 8'h10, 2);
        wait_k = 0;
        while (!m_start && wait_k < 300) begin
            @(negedge clk);
            wait_k++;
        end
        check("tmo_start_seen", m_start, 1);
        lat = 0;
        forever begin
            @(negedge clk);
            lat++;
            if (seq_done || lat >= 500) break;
        end
        check("tmo_done", seq_done, 1);
        check("tmo_latency", (lat >= TMO) && (lat <= TMO + 1), 1);
        check("tmo_err_set", seq_err, 1);
        check("tmo_rd_valid", rd_valid, 0);
        @(posedge clk);
        #1;
        model_clr = 1;
        hang_from = -1;
        flush_model();
        @(negedge clk);
        check("tmo_err_sticky", seq_err, 1);
        check("tmo_idle_ready", req_ready, 1);
        check("tmo_done_count", done_cnt - d0, 1);
        @(posedge clk);
        #1;
        run_burst(1'b1, 7'h44, 8'h20, 1);
`else
        // master never answers: the sequencer keeps waiting
        d0 = done_cnt;
        hang_from = start_cnt + 1;
        start_req(1'b0, 7'h44, 8'h10, 2);
        repeat (200) @(negedge clk);
        check("nohang_no_done", done_cnt - d0, 0);
        check("nohang_no_err", seq_err, 0);
        check("nohang_busy", req_ready, 0);
        hang_from = -1;
        pulse_reset();
        run_burst(1'b1, 7'h44, 8'h20, 1);
`endif

        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

    initial begin
        #800000;
        $display("FAIL watchdog: simulation did not finish, tests=%0d failed=%0d", tests, fails);
        $fatal(1, "watchdog");
    end

endmodule

// File: doc/i2c_reg_seq.md
Name: i2c_reg_seq

Overview:
- Register-access sequencer sitting directly upstream of i2c_master.
- Turns one burst request (device addr, start register, length, direction) into a series of single-byte i2c_master transactions.
- Each byte is a pointer-write transaction followed by a data transaction.
- Streams write bytes in and read bytes out through valid/ready handshakes, for the sensor-readout logic above it.

Parameters:
LEN_W, 4, width of burst length field (max burst 2^LEN_W-1 bytes)
TIMEOUT_CYCLES, 100000, clk cycles allowed per master transaction before abort (used only with I2C_SEQ_TIMEOUT_EN)

Ports:
clk  in  1  system clock, rising edge
rst_n  in  1  asynchronous active-low reset
req_valid  in  1  burst request present
req_ready  out  1  sequencer idle, accepts request
req_write  in  1  1=register write burst, 0=register read burst
req_dev_addr  in  7  7-bit I2C device address
req_reg_addr  in  8  first register address
req_len  in  LEN_W  number of data bytes
wr_data  in  8  write byte stream
wr_valid  in  1  write byte present
wr_ready  out  1  write byte consumed (1-cycle pulse)
rd_data  out  8  read byte
rd_valid  out  1  read byte held
rd_ready  in  1  consumer takes read byte
seq_done  out  1  1-cycle pulse, burst finished (or aborted)
seq_err  out  1  sticky abort flag, cleared on next accepted request
m_start  out  1  to i2c_master start, 1-cycle pulse
m_read_write  out  1  to i2c_master read_write
m_slave_addr  out  7  to i2c_master slave_addr
m_data_in  out  8  to i2c_master data_in
m_data_out  in  8  from i2c_master data_out
m_busy  in  1  from i2c_master busy
m_done  in  1  from i2c_master done (1-cycle pulse at transaction end)

Behaviour:
- Reset (async, any state): state IDLE.
  - All outputs 0, including req_ready; req_ready rises on the first clk edge after rst_n deasserts.
  - Counters and byte count cleared; an in-flight burst is silently dropped with no seq_done.
- States: IDLE, PTR_ISSUE, PTR_WAIT, DAT_ISSUE, DAT_WAIT, RD_HOLD, DONE.
- IDLE:
  - req_ready=1. On req_valid&req_ready, latch all req_* fields, clear seq_err and the byte counter, set req_ready=0.
  - If req_len==0, go to DONE with no master traffic; otherwise go to PTR_ISSUE.
- PTR_ISSUE:
  - Wait for m_busy==0.
  - Then drive m_read_write=0, m_data_in=current reg addr, m_slave_addr=latched addr, pulse m_start for one cycle, go to PTR_WAIT.
- PTR_WAIT: on m_done go to DAT_ISSUE.
- DAT_ISSUE, read burst: wait for m_busy==0, then pulse m_start with m_read_write=1.
- DAT_ISSUE, write burst: wait for m_busy==0 and wr_valid.
  - m_data_in=wr_data; m_start and wr_ready pulse in the same cycle, m_read_write=0.
- DAT_WAIT:
  - On m_done, a write burst goes to DONE if this was the last byte, else back to PTR_ISSUE.
  - On m_done, a read burst captures m_data_out into rd_data, sets rd_valid=1 and goes to RD_HOLD.
- RD_HOLD:
  - Hold rd_data/rd_valid until rd_ready.
  - In the rd_valid&rd_ready cycle, rd_valid drops next cycle; go to DONE if last byte, else PTR_ISSUE.
- Byte advance: after each completed byte, the byte counter increments and the reg addr increments modulo 256 (0xFF wraps to 0x00).
- DONE: seq_done=1 for exactly one cycle, then IDLE. Minimum gap between seq_done and the next req_ready=1 is 1 cycle.
- m_slave_addr, m_read_write, m_data_in stay stable from the m_start cycle until the matching m_done.
- A new request is never accepted while a burst is in progress. A glitch m_done outside PTR_WAIT/DAT_WAIT is ignored.

Optional Feature:
- Macro I2C_SEQ_TIMEOUT_EN.
- Defined:
  - A cycle counter clears on every m_start and increments in PTR_WAIT/DAT_WAIT.
  - Reaching TIMEOUT_CYCLES without m_done sets seq_err=1, drops rd_valid, goes to DONE (seq_done pulse) and then IDLE.
  - seq_err stays set until the next accepted request.
- Undefined: no counter logic; the wait states wait indefinitely and seq_err is tied 0.

Test Plan:
- Read burst dev=0x55, reg=0x3B, len=2; model returns 0xA5, 0x5A; rd_ready held 1 -> m_start pulses four times with m_data_in=0x3B, rd, 0x3C, rd; rd_data 0xA5 then 0x5A; one seq_done; seq_err=0.
- Write burst reg=0xFF, len=2, wr_data 0x3C, 0x11 -> pointer bytes 0xFF then 0x00 (wrap); data bytes 0x3C, 0x11; wr_ready pulses twice, each coincident with m_start.
- Read len=1 with rd_ready held 0 for 20 cycles -> rd_valid/rd_data stable for 20 cycles, no further m_start, seq_done only after the handshake.
- req_len=0 -> no m_start; seq_done two cycles after acceptance; req_ready returns high.
- rst_n pulsed low during DAT_WAIT of a 3-byte read -> all outputs 0 immediately; no seq_done; a fresh request after release completes normally.
- With I2C_SEQ_TIMEOUT_EN, TIMEOUT_CYCLES=50, model never asserts m_done -> seq_err=1 and seq_done pulse at 50 cycles after m_start, then IDLE; the next accepted request clears seq_err.
